// File: rtl/shift_cmd_queue.sv
// Command FIFO in front of an external combinational barrel shifter, with a
// registered valid/ready result stage so the shifter runs one command per cycle.
module shift_cmd_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   input  logic [$clog2(WIDTH)-1:0]   in_amt,
   input  logic [1:0]                 in_type,
   output logic [WIDTH-1:0]           sh_data_in,
   output logic [$clog2(WIDTH)-1:0]   sh_shift_amt,
   output logic [1:0]                 sh_shift_type,
   input  logic [WIDTH-1:0]           sh_data_out,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(WIDTH);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never depends on ready, and the payload is held until taken.

   logic [WIDTH-1:0] mem_data [DEPTH];
   logic [AW-1:0]    mem_amt  [DEPTH];
   logic [1:0]       mem_type [DEPTH];

   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [LW-1:0]    level_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;

   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             pop;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LW'(DEPTH));

   // Full means not ready even if the head is leaving this cycle.
   assign in_ready = !fifo_full;
   assign push     = in_valid && !fifo_full;
   assign pop      = !fifo_empty && (!out_valid_q || out_ready);

   // Storage needs no reset: the head is masked to zero whenever the queue is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wptr] <= in_data;
         mem_amt[wptr]  <= in_amt;
         mem_type[wptr] <= in_type;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr    <= '0;
         rptr    <= '0;
         level_q <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         level_q <= level_q + LW'(push) - LW'(pop);
      end
   end

   // Result register: loads on every pop, empties when taken without a refill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (pop) begin
         out_valid_q <= 1'b1;
         out_data_q  <= sh_data_out;
      end else if (out_valid_q && out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign sh_data_in    = fifo_empty ? '0 : mem_data[rptr];
   assign sh_shift_amt  = fifo_empty ? '0 : mem_amt[rptr];
   assign sh_shift_type = fifo_empty ? '0 : mem_type[rptr];

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign level     = level_q;

   a_level_bound : assert property (@(posedge clk) disable iff (!rst_n)
      level_q <= LW'(DEPTH));

   a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
      (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q)));

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Bench for shift_cmd_queue: attaches a behavioural barrel shifter, runs vector
// tables and directed sequences, and tracks every cycle against a queue model.
module tb_shift_cmd_queue;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int AW = $clog2(W);
   localparam int LW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b1;
   logic          in_ready;
   logic [W-1:0]  in_data = 8'h5A;
   logic [AW-1:0] in_amt = 3'd2;
   logic [1:0]    in_type = 2'b01;
   logic [W-1:0]  sh_data_in;
   logic [AW-1:0] sh_shift_amt;
   logic [1:0]    sh_shift_type;
   logic [W-1:0]  sh_data_out;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_data;
   logic [LW-1:0] level;

   always #5 clk = ~clk;

   shift_cmd_queue #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_amt(in_amt), .in_type(in_type),
      .sh_data_in(sh_data_in), .sh_shift_amt(sh_shift_amt), .sh_shift_type(sh_shift_type),
      .sh_data_out(sh_data_out),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .level(level)
   );

   // Attached shifter, bit by bit.
   always_comb begin
      sh_data_out = '0;
      for (int i = 0; i < W; i++) begin
         case (sh_shift_type)
            2'b00: if (i >= int'(sh_shift_amt)) sh_data_out[i] = sh_data_in[i - int'(sh_shift_amt)];
            2'b01: if (i + int'(sh_shift_amt) < W) sh_data_out[i] = sh_data_in[i + int'(sh_shift_amt)];
            2'b10: sh_data_out[i] = sh_data_in[(i + int'(sh_shift_amt)) % W];
            default: sh_data_out[i] = sh_data_in[(i - int'(sh_shift_amt) + W) % W];
         endcase
      end
   end

   typedef struct packed {
      logic [W-1:0]  d;
      logic [AW-1:0] a;
      logic [1:0]    t;
   } cmd_t;

   typedef struct {
      logic [W-1:0]  d;
      logic [AW-1:0] a;
      logic [1:0]    t;
      logic [W-1:0]  e;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int stalls = 0;
   int delivered = 0;
   int max_lvl = 0;
   bit rand_ordy = 1'b0;
   logic drive_ordy = 1'b1;

   cmd_t         m_q[$];
   logic [W-1:0] exp_q[$];
   logic         m_hold_v = 1'b0;
   logic [W-1:0] m_hold_d = '0;

   function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [AW-1:0] a,
                                              input logic [1:0] t);
      logic [2*W-1:0] dd;
      dd = {d, d};
      case (t)
         2'b00: return d << a;
         2'b01: return d >> a;
         2'b10: begin dd = dd >> a; return dd[W-1:0]; end
         default: begin dd = dd << a; return dd[2*W-1:W]; end
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      if (failures <= 40) $display("FAIL %s at %0t", name, $time);
   endtask

   // Cycle model: FIFO of commands plus one result slot; updated per upcoming edge.
   always @(negedge clk) begin : monitor
      int n;
      logic do_pop;
      logic do_push;
      if (rst_n) begin
         n = m_q.size();
         if (int'(level) > max_lvl) max_lvl = int'(level);
         chk("mon_level", 32'(level), 32'(n));
         chk("mon_in_ready", 32'(in_ready), 32'(n < D));
         chk("mon_out_valid", 32'(out_valid), 32'(m_hold_v));
         if (m_hold_v) chk("mon_out_data", 32'(out_data), 32'(m_hold_d));
         if (n > 0) begin
            chk("mon_sh_data", 32'(sh_data_in), 32'(m_q[0].d));
            chk("mon_sh_amt", 32'(sh_shift_amt), 32'(m_q[0].a));
            chk("mon_sh_type", 32'(sh_shift_type), 32'(m_q[0].t));
         end else begin
            chk("mon_sh_idle", 32'({sh_data_in, sh_shift_amt, sh_shift_type}), 32'd0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) fail_now("sb_unexpected_result");
            else chk("sb_order", 32'(out_data), 32'(exp_q.pop_front()));
            delivered++;
         end
         do_pop  = (n != 0) && (!m_hold_v || out_ready);
         do_push = in_valid && (n < D);
         if (do_pop) begin
            m_hold_d = ref_shift(m_q[0].d, m_q[0].a, m_q[0].t);
            m_hold_v = 1'b1;
            void'(m_q.pop_front());
         end else if (m_hold_v && out_ready) begin
            m_hold_v = 1'b0;
         end
         if (do_push) begin
            m_q.push_back(cmd_t'{in_data, in_amt, in_type});
            exp_q.push_back(ref_shift(in_data, in_amt, in_type));
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ordy) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input logic [W-1:0] d, input logic [AW-1:0] a, input logic [1:0] t);
      int waited;
      waited = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = d;
      in_amt   = a;
      in_type  = t;
      if (!rand_ordy) out_ready = drive_ordy;
      @(negedge clk);
      while (!in_ready && waited < 64) begin
         waited++;
         stalls++;
         @(negedge clk);
      end
      if (!in_ready) fail_now("send_timeout");
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = W'($urandom);
      if (!rand_ordy) out_ready = drive_ordy;
   endtask

   task automatic drain();
      int cyc;
      drive_ordy = 1'b1;
      idle();
      #2;
      rand_ordy = 1'b0;
      out_ready = 1'b1;
      cyc = 0;
      @(negedge clk);
      while (!(level == '0 && !out_valid) && cyc < 64) begin
         cyc++;
         @(negedge clk);
      end
      if (level != '0 || out_valid) fail_now("drain_timeout");
   endtask

   task automatic send_rand();
      send(W'($urandom), AW'($urandom_range(0, W - 1)), 2'($urandom_range(0, 3)));
   endtask

   vec_t vecs[8];
   cmd_t c0;
   int   d0;

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h81, 3'd1, 2'b00, 8'h02};
      vecs[1] = '{8'h80, 3'd7, 2'b01, 8'h01};
      vecs[2] = '{8'hB1, 3'd3, 2'b10, 8'h36};
      vecs[3] = '{8'h81, 3'd1, 2'b11, 8'h03};
      vecs[4] = '{8'hA5, 3'd0, 2'b10, 8'hA5};
      vecs[5] = '{8'h3C, 3'd0, 2'b00, 8'h3C};
      vecs[6] = '{8'h01, 3'd7, 2'b11, 8'h80};
      vecs[7] = '{8'hFF, 3'd7, 2'b00, 8'h80};

      // Reset held with a command offered.
      repeat (3) @(negedge clk);
      chk("reset_level", 32'(level), 0);
      chk("reset_out_valid", 32'(out_valid), 0);
      chk("reset_out_data", 32'(out_data), 0);
      chk("reset_in_ready", 32'(in_ready), 1);
      chk("reset_sh", 32'({sh_data_in, sh_shift_amt, sh_shift_type}), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_level", 32'(level), 0);

      // Single commands: head visible one cycle after push, result the next.
      for (int i = 0; i < 8; i++) begin
         send(vecs[i].d, vecs[i].a, vecs[i].t);
         idle();
         @(negedge clk);
         chk("vec_sh_data", 32'(sh_data_in), 32'(vecs[i].d));
         chk("vec_sh_amt", 32'(sh_shift_amt), 32'(vecs[i].a));
         chk("vec_sh_type", 32'(sh_shift_type), 32'(vecs[i].t));
         chk("vec_early_valid", 32'(out_valid), 0);
         @(negedge clk);
         chk("vec_valid", 32'(out_valid), 1);
         chk("vec_result", 32'(out_data), 32'(vecs[i].e));
         @(negedge clk);
         chk("vec_consumed", 32'(out_valid), 0);
      end

      // Back-to-back stream.
      stalls = 0;
      max_lvl = 0;
      d0 = delivered;
      for (int i = 0; i < 16; i++) send_rand();
      chk("stream_stalls", 32'(stalls), 0);
      drain();
      chk("stream_max_level_le1", 32'(max_lvl <= 1), 1);
      chk("stream_delivered", 32'(delivered - d0), 16);

      // Backpressure: five fit (four queued, one held), sixth waits.
      drive_ordy = 1'b0;
      stalls = 0;
      d0 = delivered;
      c0 = cmd_t'{8'hC3, 3'd2, 2'b10};
      send(c0.d, c0.a, c0.t);
      for (int i = 0; i < 4; i++) send_rand();
      chk("bp_no_stall", 32'(stalls), 0);
      @(posedge clk);
      #1;
      in_data = 8'h96;
      in_amt  = 3'd5;
      in_type = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(in_ready), 0);
         chk("bp_level", 32'(level), 4);
         chk("bp_hold_data", 32'(out_data), 32'(ref_shift(c0.d, c0.a, c0.t)));
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      drive_ordy = 1'b1;
      @(negedge clk);
      chk("bp_release_not_ready", 32'(in_ready), 0);
      @(negedge clk);
      chk("bp_release_ready", 32'(in_ready), 1);
      drain();
      chk("bp_delivered", 32'(delivered - d0), 6);

      // Simultaneous push and pop at level 2.
      drive_ordy = 1'b0;
      for (int i = 0; i < 3; i++) send_rand();
      drive_ordy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_rand();
         chk("pushpop_level", 32'(level), 2);
      end
      drain();

      // Pointer wrap with random consumer.
      idle();
      #2;
      rand_ordy = 1'b1;
      d0 = delivered;
      for (int i = 0; i < 3 * D; i++) begin
         if ($urandom_range(0, 3) == 0) idle();
         send_rand();
      end
      drain();
      chk("wrap_delivered", 32'(delivered - d0), 3 * D);

      // Reset mid-operation.
      drive_ordy = 1'b0;
      for (int i = 0; i < 4; i++) send_rand();
      idle();
      @(negedge clk);
      chk("mid_pre_level", 32'(level), 3);
      chk("mid_pre_valid", 32'(out_valid), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_level", 32'(level), 0);
      chk("mid_rst_in_ready", 32'(in_ready), 1);
      chk("mid_rst_out_data", 32'(out_data), 0);
      m_q.delete();
      exp_q.delete();
      m_hold_v = 1'b0;
      m_hold_d = '0;
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      drive_ordy = 1'b1;
      send(8'h0F, 3'd4, 2'b00);
      idle();
      @(negedge clk);
      chk("post_mid_early_valid", 32'(out_valid), 0);
      @(negedge clk);
      chk("post_mid_valid", 32'(out_valid), 1);
      chk("post_mid_result", 32'(out_data), 32'h0F0);
      drain();
      chk("final_sb_empty", 32'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
